// File: rtl/mmr_trigger_pkg.sv
// ---------------------------------------------------------------------------
// mmr_trigger_pkg
// Shared types and helpers for the MMR trigger arbiter.
//   flat_idx_t       : container for a flat trigger index f = reg*WIDTH + bit
//   trig_arb_state_e : arbiter FSM states (SCAN, OFFER, DRAIN)
//   flat_to_reg/bit  : split a flat index back into register / bit position
// ---------------------------------------------------------------------------
package mmr_trigger_pkg;

  typedef logic [31:0] flat_idx_t;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    OFFER = 2'd1,
    DRAIN = 2'd2
  } trig_arb_state_e;

  // Register index that holds flat position 'flat'
  function automatic flat_idx_t flat_to_reg(input flat_idx_t flat, input flat_idx_t width);
    return flat / width;
  endfunction

  // Bit position inside its register for flat position 'flat'
  function automatic flat_idx_t flat_to_bit(input flat_idx_t flat, input flat_idx_t width);
    return flat % width;
  endfunction

endpackage

// File: rtl/mmr_rr_picker.sv
// ---------------------------------------------------------------------------
// mmr_rr_picker
// Combinational rotate-priority encoder. Starting at 'rr' and wrapping modulo
// TOTAL, returns the first set bit of 'elig'.
//   elig  in  [TOTAL-1:0] eligible trigger bits (flat index)
//   rr    in  [FW-1:0]    search start position (always < TOTAL)
//   found out 1           at least one eligible bit exists
//   idx   out [FW-1:0]    flat index of the winner (0 when !found)
// ---------------------------------------------------------------------------
module mmr_rr_picker #(
  parameter int TOTAL = 128,
  parameter int FW    = 7
) (
  input  logic [TOTAL-1:0] elig,
  input  logic [FW-1:0]    rr,
  output logic             found,
  output logic [FW-1:0]    idx
);

  int unsigned pos;

  // Walk the ring from rr; the first eligible position seen wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < TOTAL; i++) begin
      pos = 32'(rr) + i;
      // explicit wrap so non power-of-two totals work
      if (pos >= TOTAL) begin
        pos = pos - TOTAL;
      end else begin
        pos = pos;
      end
      if (!found && elig[pos[FW-1:0]]) begin
        found = 1'b1;
        idx   = pos[FW-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mmr_trigger_arbiter.sv
// ---------------------------------------------------------------------------
// mmr_trigger_arbiter
// Round-robin arbiter between N x WIDTH trigger status bits and one consumer.
// A pending, unmasked bit is offered over valid/ready; on acceptance a single
// clear pulse is sent back for that bit and the arbiter waits (DRAIN) until
// the bit reads 0 or CLEAR_TIMEOUT cycles have passed since the pulse.
//   clock          in  sole clock, rising edge
//   resetn         in  synchronous active-low reset
//   tsr            in  [N-1:0][WIDTH-1:0] trigger status (1 = pending)
//   tsr_mask       in  [N-1:0][WIDTH-1:0] per-bit enable
//   tsr_invpulses  out [N-1:0][WIDTH-1:0] one-cycle clear pulses (one-hot/zero)
//   trig_valid     out offer valid
//   trig_ready     in  consumer accepts
//   trig_reg       out register index of the offer
//   trig_bit       out bit index of the offer
// ---------------------------------------------------------------------------
module mmr_trigger_arbiter
  import mmr_trigger_pkg::*;
#(
  parameter int N             = 4,
  parameter int WIDTH         = 32,
  parameter int CLEAR_TIMEOUT = 8,
  localparam int RW = (N > 1) ? $clog2(N) : 1,
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [N-1:0][WIDTH-1:0]   tsr,
  input  logic [N-1:0][WIDTH-1:0]   tsr_mask,
  output logic [N-1:0][WIDTH-1:0]   tsr_invpulses,
  output logic                      trig_valid,
  input  logic                      trig_ready,
  output logic [RW-1:0]             trig_reg,
  output logic [BW-1:0]             trig_bit
);

  localparam int TOTAL = N * WIDTH;
  localparam int FW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CW    = $clog2(CLEAR_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(CLEAR_TIMEOUT);
  localparam logic [FW-1:0] LAST_C    = FW'(TOTAL - 1);

  trig_arb_state_e  state_q;
  logic [FW-1:0]    rr_q;
  logic [FW-1:0]    grant_q;      // flat index currently offered / draining
  logic [RW-1:0]    trig_reg_q;
  logic [BW-1:0]    trig_bit_q;
  logic             valid_q;
  logic [TOTAL-1:0] pulse_q;
  logic [CW-1:0]    cnt_q;        // cycles since the clear pulse, saturating

  logic [TOTAL-1:0] tsr_flat_s;
  logic [TOTAL-1:0] pend_s;
  logic [TOTAL-1:0] excl_s;
  logic [TOTAL-1:0] elig_s;
  logic [TOTAL-1:0] onehot_s;
  logic             found_s;
  logic [FW-1:0]    pick_idx_s;
  logic [RW-1:0]    pick_reg_s;
  logic [BW-1:0]    pick_bit_s;
  logic [FW-1:0]    rr_next_s;
  logic             drain_exit_s;

  assign tsr_flat_s = tsr;
  assign pend_s     = tsr & tsr_mask;
  assign elig_s     = pend_s & ~excl_s;

  // DRAIN bookkeeping: mask out the granted bit and decide when to leave.
  // The pulse cycle itself (cnt 0) never exits, the clear cannot have landed yet.
  always_comb begin
    excl_s       = '0;
    drain_exit_s = 1'b0;
    if (state_q == DRAIN) begin
      excl_s[grant_q] = 1'b1;
      drain_exit_s    = (cnt_q != '0) && (!tsr_flat_s[grant_q] || (cnt_q == TIMEOUT_C));
    end else begin
      excl_s       = '0;
      drain_exit_s = 1'b0;
    end
  end

  // Split the winner into register/bit, build the pulse vector and next rr
  always_comb begin
    pick_reg_s      = RW'(flat_to_reg(flat_idx_t'(pick_idx_s), flat_idx_t'(WIDTH)));
    pick_bit_s      = BW'(flat_to_bit(flat_idx_t'(pick_idx_s), flat_idx_t'(WIDTH)));
    onehot_s        = '0;
    onehot_s[grant_q] = 1'b1;
    if (grant_q == LAST_C) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_q + FW'(1);
    end
  end

  mmr_rr_picker #(
    .TOTAL (TOTAL),
    .FW    (FW)
  ) u_picker (
    .elig  (elig_s),
    .rr    (rr_q),
    .found (found_s),
    .idx   (pick_idx_s)
  );

  // Arbiter FSM with registered offer, pulse and timeout counter.
  // DRAIN exit can load the next winner directly so a new offer follows one
  // cycle later instead of detouring through SCAN.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= SCAN;
      rr_q       <= '0;
      grant_q    <= '0;
      trig_reg_q <= '0;
      trig_bit_q <= '0;
      valid_q    <= 1'b0;
      pulse_q    <= '0;
      cnt_q      <= '0;
    end else begin
      pulse_q <= '0;
      case (state_q)
        SCAN: begin
          if (found_s) begin
            grant_q    <= pick_idx_s;
            trig_reg_q <= pick_reg_s;
            trig_bit_q <= pick_bit_s;
            valid_q    <= 1'b1;
            state_q    <= OFFER;
          end else begin
            state_q <= SCAN;
          end
        end
        OFFER: begin
          // committed: held until accepted, whatever tsr does meanwhile
          if (valid_q && trig_ready) begin
            pulse_q <= onehot_s;
            rr_q    <= rr_next_s;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            state_q <= OFFER;
          end
        end
        DRAIN: begin
          if (cnt_q != TIMEOUT_C) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= cnt_q;
          end
          if (drain_exit_s && found_s) begin
            grant_q    <= pick_idx_s;
            trig_reg_q <= pick_reg_s;
            trig_bit_q <= pick_bit_s;
            valid_q    <= 1'b1;
            state_q    <= OFFER;
          end else if (drain_exit_s) begin
            state_q <= SCAN;
          end else begin
            state_q <= DRAIN;
          end
        end
        default: begin
          state_q <= SCAN;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tsr_invpulses = pulse_q;
  assign trig_valid    = valid_q;
  assign trig_reg      = trig_reg_q;
  assign trig_bit      = trig_bit_q;

endmodule

// File: tb/tb_mmr_trigger_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmr_trigger_arbiter
// Self-checking bench: expected grants are queued when triggers are set up and
// popped when the DUT handshakes; the clear pulse is checked on the following
// cycle. An optional consumer model clears a bit one cycle after its pulse.
// ---------------------------------------------------------------------------
module tb_mmr_trigger_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CT = 4;

  typedef struct packed {
    logic [1:0] r;
    logic [4:0] b;
  } offer_t;

  logic                  clock;
  logic                  resetn;
  logic [N-1:0][W-1:0]   tsr;
  logic [N-1:0][W-1:0]   tsr_mask;
  logic [N-1:0][W-1:0]   tsr_invpulses;
  logic                  trig_valid;
  logic                  trig_ready;
  logic [1:0]            trig_reg;
  logic [4:0]            trig_bit;

  offer_t              exp_q[$];
  int                  n_checks = 0;
  int                  n_errors = 0;
  int                  cyc      = 0;
  int                  last_acc = 0;
  int                  acc_gap  = 0;
  logic                acc_evt  = 1'b0;
  logic                auto_clear = 1'b0;
  logic [N-1:0][W-1:0] pulse_seen;

  mmr_trigger_arbiter #(
    .N             (N),
    .WIDTH         (W),
    .CLEAR_TIMEOUT (CT)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .tsr           (tsr),
    .tsr_mask      (tsr_mask),
    .tsr_invpulses (tsr_invpulses),
    .trig_valid    (trig_valid),
    .trig_ready    (trig_ready),
    .trig_reg      (trig_reg),
    .trig_bit      (trig_bit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_offer(input int r, input int b);
    offer_t e;
    e.r = 2'(r);
    e.b = 5'(b);
    exp_q.push_back(e);
  endtask

  // One clock: note a handshake before the edge, score it after the edge,
  // then let the consumer model react to the previous cycle's pulse.
  task automatic tick();
    logic         hs;
    logic [1:0]   r;
    logic [4:0]   b;
    offer_t       e;
    int           idx;
    hs = trig_valid && trig_ready && resetn;
    r  = trig_reg;
    b  = trig_bit;
    acc_evt = 1'b0;
    @(posedge clock);
    #1;
    cyc++;
    if (hs) begin
      acc_evt  = 1'b1;
      acc_gap  = (cyc - 1) - last_acc;
      last_acc = cyc - 1;
      check_val("offer_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("offer_reg", 128'(r), 128'(e.r));
        check_val("offer_bit", 128'(b), 128'(e.b));
        idx = int'(e.r) * W + int'(e.b);
      end else begin
        idx = int'(r) * W + int'(b);
      end
      check_val("pulse", tsr_invpulses, 128'd1 << idx);
    end else if (tsr_invpulses != '0) begin
      check_val("stray_pulse", tsr_invpulses, 128'd0);
    end
    if (auto_clear) tsr = tsr & ~pulse_seen;
    pulse_seen = tsr_invpulses;
  endtask

  task automatic wait_accept(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (acc_evt) break;
    end
    check_val("accept_in_budget", 128'(acc_evt), 128'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (trig_valid) break;
      tick();
    end
    check_val("valid_in_budget", 128'(trig_valid), 128'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_val("queue_drained", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    tsr        = '0;
    tsr_mask   = '1;
    trig_ready = 1'b0;
    pulse_seen = '0;
    tick();
    tick();
    check_val("rst_valid", 128'(trig_valid), 128'd0);
    check_val("rst_reg",   128'(trig_reg),   128'd0);
    check_val("rst_bit",   128'(trig_bit),   128'd0);
    check_val("rst_pulse", tsr_invpulses,    128'd0);

    // single trigger [2][5], consumer clears one cycle after the pulse
    resetn     = 1'b1;
    trig_ready = 1'b1;
    auto_clear = 1'b1;
    tsr[2][5]  = 1'b1;
    expect_offer(2, 5);
    tick();
    check_val("t1_valid", 128'(trig_valid), 128'd1);
    check_val("t1_reg",   128'(trig_reg),   128'd2);
    check_val("t1_bit",   128'(trig_bit),   128'd5);
    tick();
    check_val("t1_accepted", 128'(acc_evt), 128'd1);
    tick();
    check_val("t1_pulse_once", tsr_invpulses,    128'd0);
    check_val("t1_valid_low",  128'(trig_valid), 128'd0);
    repeat (6) tick();
    check_val("t1_idle", 128'(trig_valid), 128'd0);

    // three never-cleared bits, rr from 0: order 0/0, 1/3, 3/31, 0/0
    resetn = 1'b0;
    tick();
    resetn     = 1'b1;
    auto_clear = 1'b0;
    tsr        = '0;
    tsr[0][0]  = 1'b1;
    tsr[1][3]  = 1'b1;
    tsr[3][31] = 1'b1;
    expect_offer(0, 0);
    expect_offer(1, 3);
    expect_offer(3, 31);
    expect_offer(0, 0);
    wait_accept(20);
    for (int k = 0; k < 3; k++) begin
      wait_accept(20);
      check_val("t2_timeout_gap", 128'(acc_gap), 128'(CT + 2));
    end
    tsr        = '0;
    trig_ready = 1'b0;
    repeat (4) tick();

    // stall while offering [1][7]; bit drops but offer stays committed
    tsr[1][7] = 1'b1;
    expect_offer(1, 7);
    wait_valid(10);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("t3_hold_valid", 128'(trig_valid), 128'd1);
      check_val("t3_hold_reg",   128'(trig_reg),   128'd1);
    end
    tsr[1][7] = 1'b0;
    tick();
    check_val("t3_drop_valid", 128'(trig_valid), 128'd1);
    check_val("t3_drop_bit",   128'(trig_bit),   128'd7);
    trig_ready = 1'b1;
    wait_accept(2);
    repeat (3) tick();
    check_val("t3_idle", 128'(trig_valid), 128'd0);

    // masking: only bit 8 of register 0 may ever win
    auto_clear  = 1'b1;
    tsr[0]      = '1;
    tsr_mask[0] = 32'h0000_0100;
    expect_offer(0, 8);
    wait_accept(10);
    repeat (10) tick();
    check_val("t4_no_reoffer", 128'(trig_valid), 128'd0);
    tsr[0][8] = 1'b1;
    expect_offer(0, 8);
    wait_accept(10);
    repeat (3) tick();
    tsr      = '0;
    tsr_mask = '1;
    repeat (2) tick();

    // cleared promptly: next offer 3 cycles after acceptance
    tsr[2][0] = 1'b1;
    tsr[2][1] = 1'b1;
    expect_offer(2, 0);
    expect_offer(2, 1);
    wait_accept(10);
    wait_accept(10);
    check_val("t5_clear_gap", 128'(acc_gap), 128'd3);
    repeat (4) tick();
    check_val("t5_idle", 128'(trig_valid), 128'd0);

    // single bit never cleared: re-offered after the timeout
    auto_clear = 1'b0;
    tsr[3][0]  = 1'b1;
    expect_offer(3, 0);
    expect_offer(3, 0);
    wait_accept(10);
    wait_accept(20);
    check_val("t6_reoffer_gap", 128'(acc_gap), 128'(CT + 3));
    tsr        = '0;
    trig_ready = 1'b0;
    repeat (4) tick();

    // reset while offering with ready high: no pulse, rr back to 0
    tsr[1][2] = 1'b1;
    wait_valid(10);
    check_val("t7_offer_reg", 128'(trig_reg), 128'd1);
    check_val("t7_offer_bit", 128'(trig_bit), 128'd2);
    trig_ready = 1'b1;
    resetn     = 1'b0;
    auto_clear = 1'b1;
    tsr        = '0;
    tsr[0][0]  = 1'b1;
    tsr[3][5]  = 1'b1;
    tick();
    check_val("t7_rst_valid", 128'(trig_valid), 128'd0);
    check_val("t7_rst_pulse", tsr_invpulses,    128'd0);
    check_val("t7_rst_reg",   128'(trig_reg),   128'd0);
    resetn = 1'b1;
    expect_offer(0, 0);
    expect_offer(3, 5);
    wait_drain(30);
    repeat (4) tick();
    tsr = '0;
    repeat (2) tick();
    check_val("t7_idle", 128'(trig_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
